id_pair_packer: RTL and testbench
=================================

# id_pair_packer

Receive-side counterpart of the Tanimoto accelerator's ID-pair output stream. Accepts one 2*VEC_ID_WIDTH-bit ID pair per cycle from the accelerator's M_AXIS_ID_PAIR port and packs the pairs into BUS_WIDTH-bit AXI-Stream words for DMA write-back to host memory. Partial words are emitted on an explicit flush (end of run, tlast set) or after an idle timeout, with tkeep marking the valid bytes.

## Interface
- BUS_WIDTH, 512, output word width; must be a multiple of PAIR_WIDTH
- VEC_ID_WIDTH, 8, width of one vector ID; PAIR_WIDTH = 2*VEC_ID_WIDTH, must be a multiple of 8
- FLUSH_TIMEOUT, 256, idle cycles before a partial word is emitted; 0 disables the timeout
- Derived: PAIRS_PER_WORD = BUS_WIDTH/PAIR_WIDTH (32), KEEP_WIDTH = BUS_WIDTH/8, FILL_WIDTH = $clog2(PAIRS_PER_WORD+1)
- ap_clk  in  1  single clock for all logic
- ap_rst  in  1  synchronous, active-high reset
- S_AXIS_ID_PAIR_tdata  in  PAIR_WIDTH  ID pair from accelerator
- S_AXIS_ID_PAIR_tvalid  in  1  pair valid
- S_AXIS_ID_PAIR_tready  out  1  packer can accept a pair
- i_Flush  in  1  single-cycle end-of-run request
- M_AXIS_DATA_tdata  out  BUS_WIDTH  packed word; pair k in bits [k*PAIR_WIDTH +: PAIR_WIDTH]
- M_AXIS_DATA_tkeep  out  KEEP_WIDTH  byte enables, contiguous from LSB
- M_AXIS_DATA_tlast  out  1  final word of a flushed run
- M_AXIS_DATA_tvalid  out  1  word valid
- M_AXIS_DATA_tready  in  1  downstream accepts word
- o_PairCount  out  32  pairs accepted since reset, wraps modulo 2^32

## Operation
- Accumulator register (BUS_WIDTH) + fill count; output holding register (tdata/tkeep/tlast/tvalid).
- Accepted pair written into lane fill; fill increments. Lane 0 = first pair (LSB).
- Word launch: when the accumulator is complete (fill reaches PAIRS_PER_WORD, or flush/timeout with fill>0) and the output register is empty or being drained this cycle, the word moves to the output register, tkeep = (1 << fill*PAIR_WIDTH/8)-1, fill cleared to 0, unused lanes zero.
- S tready = 0 when: accumulator full awaiting launch, flush pending, or ap_rst high; otherwise 1.
- Flush: i_Flush sets flush_pending. A pair accepted in the same cycle as i_Flush belongs to the flushed word. Pending flush launches the partial word with tlast=1, then clears.
- Flush with fill=0: if the output register holds an unsent word, its tlast is set to 1; if both are empty, flush clears with no beat.
- i_Flush while already pending: ignored.
- Timeout: idle counter increments each cycle with fill>0 and no S handshake; resets on any S handshake or launch. At FLUSH_TIMEOUT the partial word launches with tlast=0.
- Output register holds stable until M tvalid&&tready (AXI-S rules; tvalid never drops without handshake).
- Reset mid-run: accumulator contents, pending flush and output word discarded; no beat emitted.

## Timing
- Reset values: all M_AXIS_DATA_* outputs 0, o_PairCount 0, S tready 0 during reset, 1 the first cycle after.
- Latency: handshake filling last lane in cycle N -> M tvalid in cycle N+1.
- Throughput: 1 pair/cycle sustained with M tready held high; no bubble between full words.
- Backpressure: with M tready low, accepts exactly PAIRS_PER_WORD more pairs after the output register fills, then tready drops; resumes the cycle after the output handshake.
- Flush launch: cycle after i_Flush if output register free; tready returns 1 the cycle after launch.

## Structure
- Package id_pair_pkg: PAIR_WIDTH, PAIRS_PER_WORD, KEEP_WIDTH, FILL_WIDTH derivations and a keep-mask function of fill.
- One sub-module: id_pair_out_reg, the AXI-S output holding register (load, hold, tlast-set, drain).
- Accumulator, fill count, flush and timeout logic in the top module.

## Test plan
- 32 pairs 0x0001..0x0020 back-to-back, M tready=1 -> one beat, tdata lane k = k+1, tkeep all ones, tlast=0, tvalid cycle after 32nd handshake.
- 64 pairs, M tready low for 40 cycles -> tready drops after 64th pair, two beats in order after release, o_PairCount=64.
- 5 pairs then i_Flush -> one beat, tkeep=0x3FF, lanes 5..31 zero, tlast=1.
- i_Flush coincident with 32nd pair -> full word with tlast=1, no extra beat.
- 3 pairs, idle FLUSH_TIMEOUT=16 cycles -> beat with tkeep=0x3F, tlast=0, launched at 16th idle cycle.
- ap_rst asserted with fill=10 and word pending -> no beat, all outputs 0, next 32 pairs produce a clean full word.

Source files
------------

// File: rtl/id_pair_pkg.sv
// id_pair_pkg: width derivations and keep-mask helper shared by the ID-pair packer
package id_pair_pkg;
   localparam int DEF_BUS_WIDTH    = 512;
   localparam int DEF_VEC_ID_WIDTH = 8;
   localparam int MAX_KEEP_WIDTH   = 256;
   function automatic int pair_width(input int vec_id_width);
      return 2 * vec_id_width;
   endfunction
   function automatic int pairs_per_word(input int bus_width, input int vec_id_width);
      return bus_width / pair_width(vec_id_width);
   endfunction
   function automatic int keep_width(input int bus_width);
      return bus_width / 8;
   endfunction
   function automatic int fill_width(input int bus_width, input int vec_id_width);
      return $clog2(pairs_per_word(bus_width, vec_id_width) + 1);
   endfunction
   function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input int fill, input int pair_bytes);
      logic [MAX_KEEP_WIDTH-1:0] m;
      for (int i = 0; i < MAX_KEEP_WIDTH; i++) m[i] = i < fill * pair_bytes;
      return m;
   endfunction
endpackage

// File: rtl/id_pair_out_reg.sv
// id_pair_out_reg: AXI-Stream output holding register with load, hold, tlast-set and drain
module id_pair_out_reg #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [KEEP_WIDTH-1:0] load_keep,
   input  logic                  load_last,
   input  logic                  set_last,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic [KEEP_WIDTH-1:0] keep,
   output logic                  last,
   output logic                  valid
);
   // A load may coincide with the drain of the previous word; otherwise hold until the handshake
   always_ff @(posedge clk)
      if (rst) begin
         data  <= '0;
         keep  <= '0;
         last  <= 1'b0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         keep  <= load_keep;
         last  <= load_last;
         valid <= 1'b1;
      end else if (valid && ready) begin
         last  <= 1'b0;
         valid <= 1'b0;
      end else if (set_last)
         last <= 1'b1;
endmodule

// File: rtl/id_pair_packer.sv
// id_pair_packer: packs accelerator ID pairs into wide AXI-Stream words with flush and idle timeout
module id_pair_packer
   import id_pair_pkg::*;
#(
   parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
   parameter int VEC_ID_WIDTH  = DEF_VEC_ID_WIDTH,
   parameter int FLUSH_TIMEOUT = 256,
   localparam int PAIR_WIDTH     = pair_width(VEC_ID_WIDTH),
   localparam int PAIRS_PER_WORD = pairs_per_word(BUS_WIDTH, VEC_ID_WIDTH),
   localparam int KEEP_WIDTH     = keep_width(BUS_WIDTH),
   localparam int FILL_WIDTH     = fill_width(BUS_WIDTH, VEC_ID_WIDTH)
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic [PAIR_WIDTH-1:0] S_AXIS_ID_PAIR_tdata,
   input  logic                  S_AXIS_ID_PAIR_tvalid,
   output logic                  S_AXIS_ID_PAIR_tready,
   input  logic                  i_Flush,
   output logic [BUS_WIDTH-1:0]  M_AXIS_DATA_tdata,
   output logic [KEEP_WIDTH-1:0] M_AXIS_DATA_tkeep,
   output logic                  M_AXIS_DATA_tlast,
   output logic                  M_AXIS_DATA_tvalid,
   input  logic                  M_AXIS_DATA_tready,
   output logic [31:0]           o_PairCount
);
   localparam int IDLE_WIDTH = FLUSH_TIMEOUT > 1 ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam logic [IDLE_WIDTH-1:0] IDLE_LAST = IDLE_WIDTH'(FLUSH_TIMEOUT > 0 ? FLUSH_TIMEOUT - 1 : 0);
   localparam logic [FILL_WIDTH-1:0] FULL = FILL_WIDTH'(PAIRS_PER_WORD);

   logic [BUS_WIDTH-1:0]  acc, acc_nx;
   logic [FILL_WIDTH-1:0] fill, fill_nx;
   logic [IDLE_WIDTH-1:0] idle;
   logic [KEEP_WIDTH-1:0] keep_nx;
   logic flush_pending, s_ready, s_hs, out_free, timeout_hit, launch, set_last;

   assign s_ready               = !ap_rst && fill != FULL && !flush_pending;
   assign S_AXIS_ID_PAIR_tready = s_ready;
   assign s_hs                  = S_AXIS_ID_PAIR_tvalid && s_ready;
   assign out_free              = !M_AXIS_DATA_tvalid || M_AXIS_DATA_tready;
   assign fill_nx               = fill + FILL_WIDTH'(s_hs);
   assign timeout_hit           = FLUSH_TIMEOUT != 0 && fill != '0 && !s_hs && idle == IDLE_LAST;
   assign launch                = out_free && (fill_nx == FULL || (flush_pending && fill != '0) || timeout_hit);
   assign set_last              = flush_pending && fill == '0 && M_AXIS_DATA_tvalid && !M_AXIS_DATA_tready;
   assign keep_nx               = KEEP_WIDTH'(keep_mask(int'(fill_nx), PAIR_WIDTH / 8));

   // Merge the incoming pair into its lane so the pair that completes a word launches with it
   always_comb begin
      acc_nx = acc;
      for (int k = 0; k < PAIRS_PER_WORD; k++)
         if (s_hs && fill == FILL_WIDTH'(k)) acc_nx[k*PAIR_WIDTH +: PAIR_WIDTH] = S_AXIS_ID_PAIR_tdata;
   end

   // Accumulator, fill, pending flush, idle counter and accepted-pair count
   always_ff @(posedge ap_clk)
      if (ap_rst) begin
         acc           <= '0;
         fill          <= '0;
         flush_pending <= 1'b0;
         idle          <= '0;
         o_PairCount   <= '0;
      end else begin
         acc           <= launch ? '0 : acc_nx;
         fill          <= launch ? '0 : fill_nx;
         flush_pending <= flush_pending ? !(launch || fill == '0) : i_Flush && !launch;
         idle          <= (launch || s_hs) ? '0 : (fill != '0 && idle != IDLE_LAST) ? idle + 1'b1 : idle;
         o_PairCount   <= o_PairCount + 32'(s_hs);
      end

   id_pair_out_reg #(
      .DATA_WIDTH(BUS_WIDTH),
      .KEEP_WIDTH(KEEP_WIDTH)
   ) u_out (
      .clk      (ap_clk),
      .rst      (ap_rst),
      .load     (launch),
      .load_data(acc_nx),
      .load_keep(keep_nx),
      .load_last(flush_pending || i_Flush),
      .set_last (set_last),
      .ready    (M_AXIS_DATA_tready),
      .data     (M_AXIS_DATA_tdata),
      .keep     (M_AXIS_DATA_tkeep),
      .last     (M_AXIS_DATA_tlast),
      .valid    (M_AXIS_DATA_tvalid)
   );
endmodule

// File: tb/tb_id_pair_packer.sv
// tb_id_pair_packer: randomized scenario bench for id_pair_packer against a queue-based packing model
module tb_id_pair_packer;
   localparam int BW  = 512;
   localparam int VW  = 8;
   localparam int PW  = 2 * VW;
   localparam int PPW = BW / PW;
   localparam int KW  = BW / 8;
   localparam int TO  = 16;

   typedef struct packed {
      logic [BW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          flush = 1'b0;
   logic [BW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [31:0]   pair_count;
   logic [31:0]   accepted = '0;
   beat_t         expq[$];
   beat_t         obsq[$];
   logic [PW-1:0] pend[$];
   int            total = 0;
   int            bad = 0;

   id_pair_packer #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(VW), .FLUSH_TIMEOUT(TO)) dut (
      .ap_clk               (clk),
      .ap_rst               (rst),
      .S_AXIS_ID_PAIR_tdata (s_tdata),
      .S_AXIS_ID_PAIR_tvalid(s_tvalid),
      .S_AXIS_ID_PAIR_tready(s_tready),
      .i_Flush              (flush),
      .M_AXIS_DATA_tdata    (m_tdata),
      .M_AXIS_DATA_tkeep    (m_tkeep),
      .M_AXIS_DATA_tlast    (m_tlast),
      .M_AXIS_DATA_tvalid   (m_tvalid),
      .M_AXIS_DATA_tready   (m_tready),
      .o_PairCount          (pair_count)
   );

   always #5 clk = ~clk;

   // Record every output beat at the handshake, sampled mid-cycle
   always @(negedge clk)
      if (m_tvalid && m_tready) obsq.push_back({m_tdata, m_tkeep, m_tlast});

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, needed finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic emit(input logic last);
      beat_t b;
      logic [64:0] m;
      b.d = '0;
      foreach (pend[i]) b.d[i*PW +: PW] = pend[i];
      m = (65'd1 << (pend.size() * (PW / 8))) - 65'd1;
      b.k = m[KW-1:0];
      b.l = last;
      expq.push_back(b);
      pend.delete();
   endtask

   task automatic send(input int n, input bit fixed, input bit fl, output int cyc);
      cyc = 0;
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = fixed ? PW'(i + 1) : PW'($urandom);
         flush    = fl && i == n - 1;
         for (int w = 0; ; w++) begin
            @(negedge clk);
            cyc++;
            if (s_tready) break;
            if (w == 200) begin
               $display("FAIL send_stall: tready still 0 after %0d cycles, needed 1", w);
               total++;
               bad++;
               s_tvalid = 1'b0;
               flush = 1'b0;
               return;
            end
            step();
         end
         pend.push_back(s_tdata);
         accepted++;
         if (fl && i == n - 1) emit(1'b1);
         else if (pend.size() == PPW) emit(1'b0);
         step();
      end
      s_tvalid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && obsq.size() < expq.size(); i++) step();
      repeat (4) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_tvalid = 1'b1;
      step();
      step();
      @(negedge clk);
      total += 6;
      if (m_tvalid !== 1'b0) begin $display("FAIL reset_tvalid: got %b need 0", m_tvalid); bad++; end
      if (m_tdata !== '0) begin $display("FAIL reset_tdata: got %h need 0", m_tdata); bad++; end
      if (m_tkeep !== '0) begin $display("FAIL reset_tkeep: got %h need 0", m_tkeep); bad++; end
      if (m_tlast !== 1'b0) begin $display("FAIL reset_tlast: got %b need 0", m_tlast); bad++; end
      if (pair_count !== 32'd0) begin $display("FAIL reset_count: got %0d need 0", pair_count); bad++; end
      if (s_tready !== 1'b0) begin $display("FAIL reset_sready: got %b need 0", s_tready); bad++; end
      step();
      rst = 1'b0;
      s_tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (s_tready !== 1'b1) begin $display("FAIL post_reset_sready: got %b need 1", s_tready); bad++; end
      step();
   endtask

   task automatic test_full_word();
      int cyc;
      m_tready = 1'b1;
      send(PPW, 1'b1, 1'b0, cyc);
      @(negedge clk);
      total += 2;
      if (m_tvalid !== 1'b1) begin $display("FAIL full_latency: tvalid got %b need 1", m_tvalid); bad++; end
      if (cyc != PPW) begin $display("FAIL full_throughput: cycles got %0d need %0d", cyc, PPW); bad++; end
      step();
      drain();
      total++;
      if (obsq.size() != expq.size()) begin $display("FAIL full_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL full_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_back_to_back();
      int cyc;
      m_tready = 1'b1;
      send(3 * PPW, 1'b0, 1'b0, cyc);
      total++;
      if (cyc != 3 * PPW) begin $display("FAIL b2b_throughput: cycles got %0d need %0d", cyc, 3 * PPW); bad++; end
      drain();
      total += 2;
      if (pair_count !== accepted) begin $display("FAIL b2b_count: got %0d need %0d", pair_count, accepted); bad++; end
      if (obsq.size() != expq.size()) begin $display("FAIL b2b_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL b2b_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_backpressure();
      int cyc;
      m_tready = 1'b0;
      send(2 * PPW, 1'b0, 1'b0, cyc);
      total++;
      if (cyc != 2 * PPW) begin $display("FAIL bp_accept: cycles got %0d need %0d", cyc, 2 * PPW); bad++; end
      @(negedge clk);
      total++;
      if (s_tready !== 1'b0) begin $display("FAIL bp_ready_drop: got %b need 0", s_tready); bad++; end
      repeat (40) step();
      m_tready = 1'b1;
      @(negedge clk);
      total++;
      if (s_tready !== 1'b0) begin $display("FAIL bp_ready_release: got %b need 0", s_tready); bad++; end
      step();
      @(negedge clk);
      total++;
      if (s_tready !== 1'b1) begin $display("FAIL bp_ready_resume: got %b need 1", s_tready); bad++; end
      step();
      drain();
      total += 2;
      if (pair_count !== accepted) begin $display("FAIL bp_count: got %0d need %0d", pair_count, accepted); bad++; end
      if (obsq.size() != expq.size()) begin $display("FAIL bp_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL bp_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_flush_partial();
      int cyc;
      m_tready = 1'b1;
      send(5, 1'b0, 1'b0, cyc);
      flush = 1'b1;
      emit(1'b1);
      step();
      flush = 1'b0;
      @(negedge clk);
      total++;
      if (s_tready !== 1'b0) begin $display("FAIL flush_pending_ready: got %b need 0", s_tready); bad++; end
      step();
      @(negedge clk);
      total += 3;
      if (m_tvalid !== 1'b1) begin $display("FAIL flush_launch: tvalid got %b need 1", m_tvalid); bad++; end
      if (m_tkeep !== 64'h3FF) begin $display("FAIL flush_keep: got %h need 3ff", m_tkeep); bad++; end
      if (s_tready !== 1'b1) begin $display("FAIL flush_ready_return: got %b need 1", s_tready); bad++; end
      step();
      drain();
      total++;
      if (obsq.size() != expq.size()) begin $display("FAIL flush_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL flush_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_flush_coincident();
      int cyc;
      m_tready = 1'b1;
      send(PPW, 1'b0, 1'b1, cyc);
      repeat (10) step();
      total++;
      if (obsq.size() != expq.size()) begin $display("FAIL coin_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL coin_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_flush_held();
      int cyc;
      beat_t b;
      m_tready = 1'b0;
      send(PPW, 1'b0, 1'b0, cyc);
      b = expq.pop_back();
      b.l = 1'b1;
      expq.push_back(b);
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (3) step();
      m_tready = 1'b1;
      drain();
      total++;
      if (obsq.size() != expq.size()) begin $display("FAIL held_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL held_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (5) step();
      @(negedge clk);
      total += 2;
      if (obsq.size() != 0) begin $display("FAIL empty_flush_beats: got %0d need 0", obsq.size()); bad++; end
      if (s_tready !== 1'b1) begin $display("FAIL empty_flush_ready: got %b need 1", s_tready); bad++; end
      step();
      obsq.delete();
   endtask

   task automatic test_timeout();
      int cyc;
      int t;
      m_tready = 1'b1;
      send(3, 1'b0, 1'b0, cyc);
      emit(1'b0);
      t = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (m_tvalid) begin
            t = i;
            break;
         end
         step();
      end
      step();
      total++;
      if (t != TO + 1) begin $display("FAIL timeout_cycle: tvalid seen at idle cycle %0d need %0d", t, TO + 1); bad++; end
      drain();
      total++;
      if (obsq.size() != expq.size()) begin $display("FAIL timeout_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL timeout_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   task automatic test_reset_midrun();
      int cyc;
      m_tready = 1'b0;
      send(PPW + 10, 1'b0, 1'b0, cyc);
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      total += 4;
      if (m_tvalid !== 1'b0) begin $display("FAIL midrst_tvalid: got %b need 0", m_tvalid); bad++; end
      if (m_tdata !== '0) begin $display("FAIL midrst_tdata: got %h need 0", m_tdata); bad++; end
      if (m_tkeep !== '0) begin $display("FAIL midrst_tkeep: got %h need 0", m_tkeep); bad++; end
      if (pair_count !== 32'd0) begin $display("FAIL midrst_count: got %0d need 0", pair_count); bad++; end
      step();
      rst = 1'b0;
      pend.delete();
      expq.delete();
      accepted = '0;
      m_tready = 1'b1;
      step();
      send(PPW, 1'b0, 1'b0, cyc);
      drain();
      total += 2;
      if (pair_count !== accepted) begin $display("FAIL midrst_recount: got %0d need %0d", pair_count, accepted); bad++; end
      if (obsq.size() != expq.size()) begin $display("FAIL midrst_beats: got %0d need %0d", obsq.size(), expq.size()); bad++; end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         total++;
         if (obsq[i] !== expq[i]) begin $display("FAIL midrst_beat%0d: got %h need %h", i, obsq[i], expq[i]); bad++; end
      end
      obsq.delete();
      expq.delete();
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_back_to_back();
      test_backpressure();
      test_flush_partial();
      test_flush_coincident();
      test_flush_held();
      test_timeout();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
